// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer
// Drives the Spartan-3E character LCD through its 4-bit interface on behalf of
// the CPU's LCD write port. After reset it runs the 4-bit power-on init on its
// own. After that it accepts one byte plus a register-select flag per write
// strobe. It sends the upper nibble first, then the lower nibble. It then waits
// out the LCD execution time before it drops busy.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   write    in   write strobe, sampled only while busy = 0
//   rs       in   0 = command, 1 = character data
//   data     in   8-bit byte to send
//   busy     out  high during init and during any transfer or wait
//   lcd_e    out  LCD enable
//   lcd_rs   out  LCD register select
//   lcd_rw   out  always 0 (write only)
//   lcd_data out  LCD data nibble (SF_D[11:8])
//   sf_ce0   out  always 1 (StrataFlash disabled)
module lcd_nibble_writer #(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_NIBBLE  = 50,
    parameter int T_SETUP   = 2,
    parameter int T_EN      = 12,
    parameter int T_HOLD    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_data,
    output logic       sf_ce0
);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_SETUP, INIT_EN, INIT_HOLD, INIT_WAIT,
        IDLE, SETUP, EN, HOLD, GAP, WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] count_reg, count_next;
    logic [1:0]  init_idx_reg, init_idx_next;
    logic [7:0]  byte_reg, byte_next;
    logic        rs_latch_reg, rs_latch_next;
    logic        lower_reg, lower_next;      // 1 while the lower nibble is in flight

    logic        busy_next, lcd_e_next, lcd_rs_next;
    logic [3:0]  lcd_data_next;
    logic [19:0] dur;
    logic        done;
    logic        is_clear;

    // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
    assign is_clear = !rs_latch_reg && (byte_reg == 8'h01 || byte_reg == 8'h02 || byte_reg == 8'h03);

    // Length of the current state in cycles.
    always_comb begin
        dur = 20'd1;
        case (state_reg)
            PWR_WAIT:          dur = 20'(T_POWERUP);
            INIT_SETUP, SETUP: dur = 20'(T_SETUP);
            INIT_EN, EN:       dur = 20'(T_EN);
            INIT_HOLD, HOLD:   dur = 20'(T_HOLD);
            INIT_WAIT: begin
                case (init_idx_reg)
                    2'd0:    dur = 20'(T_INIT1);
                    2'd1:    dur = 20'(T_INIT2);
                    default: dur = 20'(T_CMD);
                endcase
            end
            GAP:               dur = 20'(T_NIBBLE);
            WAIT:              dur = is_clear ? 20'(T_CLEAR) : 20'(T_CMD);
            default:           dur = 20'd1;
        endcase
    end

    assign done = (count_reg == dur - 20'd1);

    // Process 1: state register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= PWR_WAIT;
            count_reg    <= 20'd0;
            init_idx_reg <= 2'd0;
            byte_reg     <= 8'd0;
            rs_latch_reg <= 1'b0;
            lower_reg    <= 1'b0;
            busy         <= 1'b1;
            lcd_e        <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_rw       <= 1'b0;
            lcd_data     <= 4'd0;
            sf_ce0       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            init_idx_reg <= init_idx_next;
            byte_reg     <= byte_next;
            rs_latch_reg <= rs_latch_next;
            lower_reg    <= lower_next;
            busy         <= busy_next;
            lcd_e        <= lcd_e_next;
            lcd_rs       <= lcd_rs_next;
            lcd_rw       <= 1'b0;
            lcd_data     <= lcd_data_next;
            sf_ce0       <= 1'b1;
        end
    end

    // Process 2: next-state logic, byte capture and the shared counter.
    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        byte_next     = byte_reg;
        rs_latch_next = rs_latch_reg;
        lower_next    = lower_reg;
        case (state_reg)
            PWR_WAIT:   if (done) state_next = INIT_SETUP;
            INIT_SETUP: if (done) state_next = INIT_EN;
            INIT_EN:    if (done) state_next = INIT_HOLD;
            INIT_HOLD:  if (done) state_next = INIT_WAIT;
            INIT_WAIT: begin
                if (done) begin
                    if (init_idx_reg == 2'd3) begin
                        state_next = IDLE;
                    end else begin
                        init_idx_next = init_idx_reg + 2'd1;
                        state_next    = INIT_SETUP;
                    end
                end
            end
            IDLE: begin
                if (write) begin
                    byte_next     = data;
                    rs_latch_next = rs;
                    lower_next    = 1'b0;
                    state_next    = SETUP;
                end
            end
            SETUP:      if (done) state_next = EN;
            EN:         if (done) state_next = HOLD;
            HOLD:       if (done) state_next = lower_reg ? WAIT : GAP;
            GAP: begin
                if (done) begin
                    lower_next = 1'b1;
                    state_next = SETUP;
                end
            end
            WAIT:       if (done) state_next = IDLE;
            default:    state_next = PWR_WAIT;
        endcase

        // The counter restarts on every state change. It is held in IDLE so that it cannot wrap.
        if (state_next != state_reg || state_reg == IDLE)
            count_next = 20'd0;
        else
            count_next = count_reg + 20'd1;
    end

    // Process 3: next values of the registered outputs, derived from the state being entered.
    always_comb begin
        busy_next     = (state_next != IDLE);
        lcd_e_next    = (state_next == EN) || (state_next == INIT_EN);
        lcd_rs_next   = lcd_rs;
        lcd_data_next = lcd_data;
        if (state_next == IDLE) begin
            lcd_rs_next   = 1'b0;
            lcd_data_next = 4'd0;
        end else if (state_next != state_reg) begin
            // Bus and RS only move on entry to a setup state.
            if (state_next == INIT_SETUP) begin
                lcd_rs_next   = 1'b0;
                lcd_data_next = (init_idx_next == 2'd3) ? 4'h2 : 4'h3;
            end else if (state_next == SETUP) begin
                lcd_rs_next   = rs_latch_next;
                lcd_data_next = lower_next ? byte_next[3:0] : byte_next[7:4];
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Testbench for lcd_nibble_writer. It uses reduced timing parameters.
// The stimulus pushes the expected {rs, nibble} of every E pulse into a queue.
// A monitor pops one entry per E rise and checks data, RS, pulse width and bus
// stability. The main sequence checks busy durations and the reset behaviour.
module tb_lcd_nibble_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       rs;
    logic [7:0] data;
    logic       busy, lcd_e, lcd_rs, lcd_rw, sf_ce0;
    logic [3:0] lcd_data;

    int tests  = 0;
    int failed = 0;

    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    lcd_nibble_writer #(
        .T_POWERUP(100), .T_INIT1(40), .T_INIT2(20), .T_CMD(30), .T_CLEAR(60),
        .T_NIBBLE(5), .T_SETUP(2), .T_EN(12), .T_HOLD(1)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .rs(rs), .data(data),
        .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .sf_ce0(sf_ce0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: this process owns the scoreboard pops.
    bit         in_pulse = 1'b0;
    int         width = 0;
    logic [3:0] pulse_nib;
    logic       pulse_rs;
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else if (lcd_e && !in_pulse) begin
            in_pulse  = 1'b1;
            width     = 1;
            pulse_nib = lcd_data;
            pulse_rs  = lcd_rs;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got rs=%0d nibble=%0h expected no pulse", lcd_rs, lcd_data);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                $display("[TB] E pulse rs=%0d nibble=%0h (expected rs=%0d nibble=%0h)", lcd_rs, lcd_data, e[4], e[3:0]);
                check("pulse_nibble", {28'd0, lcd_data}, {28'd0, e[3:0]});
                check("pulse_rs", {31'd0, lcd_rs}, {31'd0, e[4]});
            end
        end else if (lcd_e) begin
            width++;
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("pulse_width", width, 12);
            check("bus_stable", {27'd0, lcd_rs, lcd_data}, {27'd0, pulse_rs, pulse_nib});
        end
    end

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
    endtask

    // Releases reset on a falling edge and counts the edges until busy drops.
    task automatic run_init(input string name);
        int n;
        push_init();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        $display("[TB] %s: busy fell after %0d cycles", name, n);
        check(name, n, 280);
    endtask

    // Call this 1 time unit after a posedge while busy = 0.
    task automatic send(input string name, input logic r, input logic [7:0] b,
                        input int exp_cycles, input bit noise);
        int n;
        exp_q.push_back({r, b[7:4]});
        exp_q.push_back({r, b[3:0]});
        write = 1'b1; rs = r; data = b;
        @(posedge clk); #1;
        check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        rs = ~r; data = 8'hA5;
        n = 1;
        for (int k = 0; k < 2000; k++) begin
            if (noise && n >= 5 && n < 40) begin
                write = 1'b1; data = 8'h6F;
            end else begin
                write = 1'b0;
            end
            @(posedge clk); #1;
            if (!busy) break;
            n++;
        end
        write = 1'b0;
        $display("[TB] %s: rs=%0d data=%02h busy for %0d cycles", name, r, b, n);
        check({name, "_busy_len"}, n, exp_cycles);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; write = 1'b0; rs = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_e", {31'd0, lcd_e}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_data", {28'd0, lcd_data}, 32'd0);
        check("rst_ce0", {31'd0, sf_ce0}, 32'd1);

        run_init("init_len");

        send("char_H", 1'b1, 8'h48, 65, 1'b0);
        send("clear", 1'b0, 8'h01, 95, 1'b0);
        send("home", 1'b0, 8'h02, 95, 1'b0);
        send("home3", 1'b0, 8'h03, 95, 1'b0);
        send("cmd04", 1'b0, 8'h04, 65, 1'b0);
        send("data03", 1'b1, 8'h03, 65, 1'b0);
        send("ignored", 1'b1, 8'h41, 65, 1'b1);

        // Back-to-back: write stays high, so the second byte goes in on the first idle edge.
        exp_q.push_back(5'h16); exp_q.push_back(5'h1F);
        exp_q.push_back(5'h16); exp_q.push_back(5'h1C);
        write = 1'b1; rs = 1'b1; data = 8'h6F;
        @(posedge clk); #1;
        check("b2b_busy_rise", {31'd0, busy}, 32'd1);
        data = 8'h6C;
        n = 1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
            n++;
        end
        $display("[TB] b2b first: data=6f busy for %0d cycles", n);
        check("b2b_first_len", n, 65);
        @(posedge clk); #1;
        check("b2b_recapture", {31'd0, busy}, 32'd1);
        write = 1'b0;
        n = 1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (!busy) break;
            n++;
        end
        $display("[TB] b2b second: data=6c busy for %0d cycles", n);
        check("b2b_second_len", n, 65);

        // Reset during the first E pulse of a byte.
        exp_q.push_back(5'h15);
        write = 1'b1; rs = 1'b1; data = 8'h5A;
        @(posedge clk); #1;
        write = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (lcd_e) break;
            @(posedge clk); #1;
        end
        check("midreset_e_seen", {31'd0, lcd_e}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] reset mid-byte: e=%0d busy=%0d", lcd_e, busy);
        check("midreset_e_drop", {31'd0, lcd_e}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd1);
        check("midreset_data", {28'd0, lcd_data}, 32'd0);
        repeat (3) @(posedge clk);
        run_init("reinit_len");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("idle_rw", {31'd0, lcd_rw}, 32'd0);
        check("idle_ce0", {31'd0, sf_ce0}, 32'd1);
        check("idle_data", {28'd0, lcd_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
